// File: rtl/track_fifo_pkg.sv
// Shared constants and types for the track FIFO with eager fanout fork.
package track_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_NUM_DEST = 9;
    localparam int unsigned DEFAULT_DEPTH    = 2;

    // Occupancy counter for the default depth (holds 0..DEPTH inclusive).
    typedef logic [$clog2(DEFAULT_DEPTH + 1)-1:0] count_t;

    // One bit per fanout destination (decoded select).
    typedef logic [DEFAULT_NUM_DEST-1:0] dest_mask_t;

endpackage

// File: rtl/eager_fork_mask.sv
// Eager fork: each connected destination takes the head independently; the
// head retires once every connected destination has either taken it in an
// earlier cycle or takes it in the current one.
module eager_fork_mask #(
    parameter int unsigned NUM_DEST = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                head_valid,
    input  logic [NUM_DEST-1:0] mask,
    input  logic [NUM_DEST-1:0] out_ready,
    input  logic                pop,
    output logic [NUM_DEST-1:0] out_valid,
    output logic                done
);

    logic [NUM_DEST-1:0] taken;
    logic [NUM_DEST-1:0] need;
    logic [NUM_DEST-1:0] fire;

    // Per-destination handshake and the all-taken condition for retiring the head.
    always_comb begin
        need      = mask & ~taken;
        out_valid = {NUM_DEST{head_valid}} & need;
        fire      = out_valid & out_ready;
        done      = &(~mask | taken | fire);
    end

    // Remember which destinations already have the current head; clear on retire.
    // head_valid arrives gated by clk_en, so fire and pop are both 0 during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken <= '0;
        end else if (pop) begin
            taken <= '0;
        end else begin
            taken <= taken | fire;
        end
    end

endmodule

// File: rtl/track_fifo_fork.sv
// Routing-track FIFO (or combinational bypass) feeding an eager fanout fork.
module track_fifo_fork
    import track_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned NUM_DEST = DEFAULT_NUM_DEST,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                cfg_fifo_en,
    input  logic [NUM_DEST-1:0] cfg_dest_mask,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [NUM_DEST-1:0] out_valid,
    input  logic [NUM_DEST-1:0] out_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic active;
    logic head_valid;
    logic head_valid_gated;
    logic done;
    logic push;
    logic pop;

    assign active           = clk_en & ~reset;
    assign head_valid_gated = head_valid & active;

    // Mode mux: registered head from storage, or the upstream beat passed straight through.
    always_comb begin
        if (cfg_fifo_en) begin
            head_valid = (count != '0);
            out_data   = mem[rd_ptr];
            in_ready   = (count != CNT_FULL) & active;
        end else begin
            head_valid = in_valid;
            out_data   = in_data;
            in_ready   = done & active;
        end
    end

    // Storage is only written in FIFO mode; in bypass the pop is the upstream handshake.
    always_comb begin
        push = cfg_fifo_en & in_valid & in_ready;
        pop  = head_valid & done & clk_en;
    end

    eager_fork_mask #(
        .NUM_DEST(NUM_DEST)
    ) u_fork (
        .clk       (clk),
        .reset     (reset),
        .head_valid(head_valid_gated),
        .mask      (cfg_dest_mask),
        .out_ready (out_ready),
        .pop       (pop),
        .out_valid (out_valid),
        .done      (done)
    );

    // Data storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; held at zero in bypass mode.
    always_ff @(posedge clk) begin
        if (reset || !cfg_fifo_en) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/track_fifo_fork.md
# track_fifo_fork

2-entry ready/valid track FIFO with an eager fork to up to NUM_DEST interconnect destinations. Sits on a CGRA routing track directly upstream of the fanout ready-combine stage. It owns the track's data and valid. Each connected destination gets its own valid and ready, and the head entry retires only once every connected destination has taken it.

## Interface
**Parameters**
- WIDTH, 16: data width of the track.
- NUM_DEST, 9: number of fanout destinations.
- DEPTH, 2: FIFO entries. The bench uses only 2; any power of 2 ≥ 2 is legal.

**Ports**
- clk  in  1  the single clock.
- reset  in  1  synchronous reset, active high.
- clk_en  in  1  stall when low.
- cfg_fifo_en  in  1  selects the mode: 1 = registered FIFO, 0 = combinational bypass.
- cfg_dest_mask  in  NUM_DEST  bit i = destination i connected (decoded select).
- in_data  in  WIDTH  upstream data.
- in_valid  in  1  upstream valid.
- in_ready  out  1  upstream ready.
- out_data  out  WIDTH  head data, broadcast to all destinations.
- out_valid  out  NUM_DEST  per-destination valid.
- out_ready  in  NUM_DEST  per-destination ready.

## Operation
**State**
- Storage array mem[DEPTH], rd_ptr, wr_ptr and count (0..DEPTH).
- taken[NUM_DEST]: one bit per destination.

**Fork logic**
- need[i] = cfg_dest_mask[i] & ~taken[i].
- head_valid = (count != 0) in FIFO mode; head_valid = in_valid in bypass mode.
- out_valid[i] = head_valid & need[i] & clk_en & ~reset.
- fire[i] = out_valid[i] & out_ready[i].
- done = AND over i of (~cfg_dest_mask[i] | taken[i] | fire[i]).
- pop = head_valid & done & clk_en.
- On pop, taken is cleared to 0. Otherwise taken |= fire.

**FIFO mode**
- push = in_valid & in_ready.
- in_ready = (count != DEPTH) & clk_en & ~reset. It has no combinational dependence on out_ready.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- out_data = mem[rd_ptr].

**Bypass mode (cfg_fifo_en = 0)**
- out_data = in_data.
- in_ready = done & clk_en & ~reset.
- count and the pointers are ignored and held at 0.
- taken still accumulates, so partial acceptance across cycles is legal and still eager.

**Edge cases**
- cfg_dest_mask all zero: the block behaves as a sink. done = 1, so every valid head pops immediately, with no out_valid asserted.
- cfg_* is static during operation and may change only while reset is high or count = 0 with taken = 0. Other changes are unsupported.
- clk_en low: all state holds and in_ready and all out_valid are 0. taken is not altered.

## Timing
**Reset values** (at the first clk edge with reset high, and while reset stays high)
- count = 0, pointers = 0, taken = 0.
- in_ready = 0, out_valid = 0, out_data = mem[0] (don't care).
- Reset mid-transfer discards all entries and partial-take state. No output glitch is required beyond combinational settling.

**Latency and throughput**
- FIFO mode: 1-cycle latency. A push at edge N makes out_valid visible in cycle N+1.
- FIFO mode: sustained 1 transfer per cycle when all connected destinations are ready every cycle (DEPTH = 2).
- Bypass mode: 0-cycle latency. in_valid → out_valid and out_ready → in_ready are purely combinational.

**Hold rules**
- out_data is held stable while any out_valid bit is high and the head has not popped.
- A destination whose fire occurred in an earlier cycle sees out_valid[i] = 0 until the next head.

**Full/empty boundaries**
- Full with a pop in a cycle: in_ready is still 0 in that cycle, and the next cycle shows in_ready = 1.
- Empty: out_valid = 0, regardless of in_valid in FIFO mode.

## Structure
- Package track_fifo_pkg holds:
  - constants DEFAULT_WIDTH = 16, DEFAULT_NUM_DEST = 9, DEFAULT_DEPTH = 2;
  - typedef count_t (clog2(DEPTH+1) bits);
  - typedef dest_mask_t.
- One sub-module, eager_fork_mask, contains the taken register plus the need, fire and done logic. It is parameterised by NUM_DEST, has inputs head_valid, mask, out_ready and pop, and outputs out_valid and done.
- The top level holds storage, pointers, count, the mode mux and the clk_en gating.

## Test plan
- **FIFO fill:** FIFO mode, mask = 9'h003, all out_ready = 0. Push 0xAAAA then 0xBBBB → count = 2, in_ready = 0, out_valid = 9'h003 with out_data = 0xAAAA; third in_valid is not accepted.
- **Eager fork:** mask = 9'h007 with one entry 0x1234. Cycle 1: out_ready = 9'h001. Cycle 2: out_ready = 9'h006. → out_valid goes 7 → 6 → pop at the end of cycle 2; taken returns to 0 and count = 0.
- **Streaming:** mask = 9'h1FF, all ready. Stream 0..99 back-to-back → 100 outputs in order, first one cycle after the first push, and no bubbles.
- **Bypass:** cfg_fifo_en = 0, mask = 9'h005, in_valid = 1, in_data = 0x00FF, out_ready = 9'h004 → same-cycle out_valid = 9'h005 and in_ready = 0. The next cycle, with out_ready = 9'h001, gives in_ready = 1.
- **Sink and stall:** mask = 0 → every in_valid is accepted in FIFO mode and drained the next cycle with out_valid = 0. clk_en = 0 for 3 cycles mid-stream → no state change, in_ready = 0 and out_valid = 0.
- **Reset mid-operation:** count = 2 with taken = 9'h001, then reset for 1 cycle → count = 0, taken = 0, in_ready = 0 during reset and 1 the cycle after.
